averager_reader: RTL and testbench

Read-side sequencer for the averaging accumulator memory. It sits on the opposite port of the accumulator BRAM from the averaging write controller. When an averaging run has completed and `ready` is high, a `start` pulse makes it sweep BRAM indices 0..count_max. It streams the accumulated sums out as an AXI4-Stream master toward the DMA/FIFO path and absorbs BRAM read latency and downstream backpressure with a credit-controlled skid FIFO.

---
 rtl/averager_reader_if.sv | 23 ++
 rtl/averager_reader.sv | 179 +++++++++++++++++
 tb/tb_averager_reader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/averager_reader_if.sv
// BRAM read port plus AXI4-Stream master bundle used by averager_reader.
interface averager_reader_if #(
    parameter int FAST_COUNT_WIDTH = 13,
    parameter int DATA_WIDTH       = 32
);
    logic [FAST_COUNT_WIDTH+1:0] bram_addr;
    logic                        bram_en;
    logic [DATA_WIDTH-1:0]       bram_rddata;
    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;

    modport master (
        output bram_addr, bram_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  bram_rddata, m_axis_tready
    );

    modport slave (
        input  bram_addr, bram_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output bram_rddata, m_axis_tready
    );
endinterface

// File: rtl/averager_reader.sv
// Sweeps accumulator BRAM indices 0..count_max and streams the sums over AXI4-Stream.
// Optional n_avg header beat enabled by defining AVERAGER_READER_HEADER_EN.
module averager_reader #(
    parameter int FAST_COUNT_WIDTH = 13,
    parameter int SLOW_COUNT_WIDTH = 19,
    parameter int DATA_WIDTH       = 32,
    parameter int BRAM_LATENCY     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        ready,
    input  logic [FAST_COUNT_WIDTH-1:0] count_max,
    input  logic [SLOW_COUNT_WIDTH-1:0] n_avg,
    output logic                        busy,
    output logic                        done,
    averager_reader_if.master           bus
);
    localparam int DEPTH = BRAM_LATENCY + 1;
    localparam int CW    = 4;
    localparam int PW    = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        READ   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t                      state_r, state_next_s;
    logic [FAST_COUNT_WIDTH:0]   idx_r;
    logic [FAST_COUNT_WIDTH-1:0] count_max_r;
    logic [SLOW_COUNT_WIDTH-1:0] n_avg_r;
    logic [BRAM_LATENCY-1:0]     vld_pipe_r, last_pipe_r;
    logic [DATA_WIDTH:0]         fifo_mem_r [DEPTH];
    logic [PW-1:0]               wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]               fifo_count_r;
    logic                        done_r;

    logic          accept_s, issue_s, issue_last_s, pop_s, push_s, fifo_empty_s, hdr_beat_s;
    logic [CW-1:0] inflight_s, fifo_after_pop_s;

    function automatic logic [CW-1:0] ones_count(input logic [BRAM_LATENCY-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) begin
            n = n + {{(CW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check counts reads still in the BRAM pipe plus FIFO words left after this cycle's pop.
    always_comb begin
        fifo_empty_s     = (fifo_count_r == '0);
`ifdef AVERAGER_READER_HEADER_EN
        hdr_beat_s       = (state_r == HEADER);
`else
        hdr_beat_s       = 1'b0;
`endif
        pop_s            = !fifo_empty_s && bus.m_axis_tready;
        push_s           = vld_pipe_r[BRAM_LATENCY-1];
        inflight_s       = ones_count(vld_pipe_r);
        fifo_after_pop_s = fifo_count_r - {{(CW-1){1'b0}}, pop_s};
        accept_s         = (state_r == IDLE) && start && ready;
        issue_s          = (state_r == READ) && ((inflight_s + fifo_after_pop_s) < CW'(DEPTH));
        issue_last_s     = (idx_r == {1'b0, count_max_r});
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef AVERAGER_READER_HEADER_EN
                    state_next_s = HEADER;
`else
                    state_next_s = READ;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
`ifdef AVERAGER_READER_HEADER_EN
            HEADER: begin
                if (bus.m_axis_tready) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = HEADER;
                end
            end
`endif
            READ: begin
                if (issue_s && issue_last_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = READ;
                end
            end
            DRAIN: begin
                if ((inflight_s == '0) && (fifo_after_pop_s == '0)) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; everything is derived from registered state so reset clears it at once.
    always_comb begin
        bus.bram_en       = issue_s;
        bus.bram_addr     = issue_s ? {idx_r[FAST_COUNT_WIDTH-1:0], 2'b00} : '0;
        bus.m_axis_tvalid = !fifo_empty_s || hdr_beat_s;
        if (hdr_beat_s) begin
            bus.m_axis_tdata = DATA_WIDTH'(n_avg_r);
            bus.m_axis_tlast = 1'b0;
        end else if (!fifo_empty_s) begin
            bus.m_axis_tdata = fifo_mem_r[rd_ptr_r][DATA_WIDTH-1:0];
            bus.m_axis_tlast = fifo_mem_r[rd_ptr_r][DATA_WIDTH];
        end else begin
            bus.m_axis_tdata = '0;
            bus.m_axis_tlast = 1'b0;
        end
        busy = (state_r != IDLE);
        done = done_r;
    end

    // Control state, read-latency pipeline and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            count_max_r  <= '0;
            n_avg_r      <= '0;
            vld_pipe_r   <= '0;
            last_pipe_r  <= '0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            done_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            done_r  <= (state_r == DRAIN) && (state_next_s == IDLE);
            if (accept_s) begin
                idx_r       <= '0;
                count_max_r <= count_max;
                n_avg_r     <= n_avg;
            end else if (issue_s) begin
                idx_r <= idx_r + (FAST_COUNT_WIDTH + 1)'(1);
            end
            vld_pipe_r[0]  <= issue_s;
            last_pipe_r[0] <= issue_s && issue_last_s;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
            end
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            fifo_count_r <= fifo_after_pop_s + {{(CW-1){1'b0}}, push_s};
        end
    end

    // FIFO storage: {tlast, data}, captured the cycle the BRAM word is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {last_pipe_r[BRAM_LATENCY-1], bus.bram_rddata};
        end
    end
endmodule

// File: tb/tb_averager_reader.sv
// Directed bench for averager_reader: BRAM model, scoreboard queue and AXIS protocol monitor.
module tb_averager_reader;
    localparam int FCW   = 4;
    localparam int SCW   = 19;
    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 1;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst, start, ready, busy, done;
    logic [FCW-1:0] count_max;
    logic [SCW-1:0] n_avg;

    averager_reader_if #(.FAST_COUNT_WIDTH(FCW), .DATA_WIDTH(DW)) bus ();

    averager_reader #(
        .FAST_COUNT_WIDTH(FCW),
        .SLOW_COUNT_WIDTH(SCW),
        .DATA_WIDTH(DW),
        .BRAM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ready(ready),
        .count_max(count_max),
        .n_avg(n_avg),
        .busy(busy),
        .done(done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int    checks = 0, passes = 0, fails = 0;
    int    cyc = 0, c0 = 0, d0 = 0;
    int    exp_idx, issued, data_acc, beats_acc, done_cnt = 0, last_hs_cyc, last_en_addr;
    bit    hdr_pending, expect_done, prev_stall;
    logic [DW+1:0] prev_word;
    beat_t sb_q[$];

    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_pipe [LAT];

    // BRAM model: registered read, LAT cycles; garbage on non-read cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_pipe[0] <= bus.bram_en ? mem[bus.bram_addr[FCW+1:2]] : (32'hBAD0_0000 + DW'(cyc));
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.bram_rddata = rd_pipe[LAT-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor and scoreboard consumer, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
        end else begin
            beat_t e;
            bit    hs;
            if (prev_stall)
                chk("axis_hold", {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}, prev_word);
            hs = bus.m_axis_tvalid && bus.m_axis_tready;
            if (hs) begin
                if (sb_q.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", bus.m_axis_tdata, e.data);
                    chk("beat_last", bus.m_axis_tlast, e.last);
                end
                beats_acc++;
                if (hdr_pending) hdr_pending = 1'b0;
                else data_acc++;
                if (bus.m_axis_tlast) last_hs_cyc = cyc;
            end
            if (bus.bram_en) begin
                issued++;
                chk("bram_addr", bus.bram_addr, exp_idx * 4);
                last_en_addr = bus.bram_addr;
                exp_idx++;
                chk("credit", (issued - data_acc) <= DEPTH, 1);
            end
            if (done || expect_done) chk("done_pulse", done, expect_done);
            if (done) begin
                done_cnt++;
                chk("busy_fall", busy, 0);
            end
            expect_done = hs && bus.m_axis_tlast;
            prev_stall  = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_word   = {bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata};
        end
    end

    task automatic chk_zero(input string tag);
        chk(tag, {bus.bram_addr, bus.bram_en, bus.m_axis_tdata, bus.m_axis_tvalid,
                  bus.m_axis_tlast, busy, done}, 64'd0);
    endtask

    task automatic begin_run(input int cm, input int na);
        count_max = FCW'(cm);
        n_avg     = SCW'(na);
        ready     = 1'b1;
        start     = 1'b1;
        sb_q.delete();
        hdr_pending = 1'b0;
`ifdef AVERAGER_READER_HEADER_EN
        sb_q.push_back({1'b0, DW'(SCW'(na))});
        hdr_pending = 1'b1;
`endif
        for (int i = 0; i <= cm; i++) sb_q.push_back({(i == cm), mem[i]});
        exp_idx = 0; issued = 0; data_acc = 0; beats_acc = 0;
        c0 = cyc; d0 = done_cnt;
        tick();
        start     = 1'b0;
        ready     = 1'b0;
        count_max = '0;
        n_avg     = '0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit bp);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            bus.m_axis_tready = bp ? 1'($urandom_range(1, 0)) : 1'b1;
            tick();
            n++;
        end
        bus.m_axis_tready = 1'b1;
        chk({tag, "_done"}, done_cnt - d0, 1);
        chk({tag, "_sb_empty"}, sb_q.size(), 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; count_max = '0; n_avg = '0;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = DW'((i + 1) * 10);
        tick(); tick();
        chk_zero("reset_outputs");
        rst = 1'b0;
        tick();

        // Basic readout of 10,20,30,40.
        begin_run(3, 5);
        #1;
`ifndef AVERAGER_READER_HEADER_EN
        chk("first_en", bus.bram_en, 1);
        chk("busy_high", busy, 1);
        tick(); chk("tvalid_c2", bus.m_axis_tvalid, 0);
        tick(); chk("tvalid_c3", bus.m_axis_tvalid, 0);
        tick(); chk("tvalid_c4", bus.m_axis_tvalid, 1);
`endif
        wait_done("basic", 50, 1'b0);
`ifndef AVERAGER_READER_HEADER_EN
        chk("basic_last_cycle", last_hs_cyc - c0, 3 + LAT + 2);
`endif
        chk("basic_beats", data_acc, 4);

        // Backpressure with random data.
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        begin_run(15, 7);
        wait_done("bp", 500, 1'b1);
        chk("bp_beats", data_acc, 16);

        // Start with ready low is ignored.
        issued = 0;
        ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("noready_busy", busy, 0);
        chk("noready_en", issued, 0);

        // Second start mid-run does not restart.
        begin_run(15, 9);
        tick(); tick(); tick();
        start = 1'b1; ready = 1'b1; count_max = FCW'(2);
        tick();
        start = 1'b0; ready = 1'b0;
        wait_done("restart", 200, 1'b0);
        chk("restart_beats", data_acc, 16);

        // Reset at beat 5 of 16.
        begin_run(15, 3);
        for (int n = 0; n < 100 && beats_acc < 5; n++) begin
            bus.m_axis_tready = 1'($urandom_range(1, 0));
            tick();
        end
        bus.m_axis_tready = 1'b1;
        chk("reached_beat5", beats_acc >= 5, 1);
        rst = 1'b1;
        #1;
        chk_zero("midrun_reset");
        sb_q.delete();
        d0 = done_cnt;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("no_done_after_abort", done_cnt - d0, 0);
        begin_run(3, 3);
        wait_done("after_reset", 50, 1'b0);

        // Maximum size: all-ones count_max.
        begin_run(15, 11);
        wait_done("max", 100, 1'b0);
        chk("max_beats", data_acc, 16);
        chk("max_last_addr", last_en_addr, 60);
`ifndef AVERAGER_READER_HEADER_EN
        chk("max_last_cycle", last_hs_cyc - c0, 15 + LAT + 2);
`endif

`ifdef AVERAGER_READER_HEADER_EN
        // Header beat held under backpressure.
        bus.m_axis_tready = 1'b0;
        begin_run(1, 1000);
        #1;
        chk("hdr_tvalid", bus.m_axis_tvalid, 1);
        chk("hdr_tdata", bus.m_axis_tdata, 1000);
        chk("hdr_tlast", bus.m_axis_tlast, 0);
        chk("hdr_no_read", bus.bram_en, 0);
        tick(); tick();
        wait_done("header", 50, 1'b0);
        chk("hdr_beats", beats_acc, 3);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
